// File: rtl/scan_pkg.sv
// Shared types and constants for the scan-chain load/unload engine.
// Holds FSM encoding, default chain length and parser command bytes.
package scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    EMIT,
    DONE
  } state_t;

  localparam int CHAIN_LEN_DEF = 1919;

  localparam logic [7:0] CMD_SCAN = 8'h73;
  localparam logic [7:0] CMD_GET  = 8'h67;

endpackage

// File: rtl/scan_chain_ctrl_if.sv
// Byte streams between the command parser and the scan engine.
// master: parser side; slave: scan engine side.
interface scan_chain_ctrl_if;

  logic [7:0] in_data_i;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [7:0] out_data_o;
  logic       out_valid_o;
  logic       out_ready_i;

  modport master (
    output in_data_i, in_valid_i, out_ready_i,
    input  in_ready_o, out_data_o, out_valid_o
  );

  modport slave (
    input  in_data_i, in_valid_i, out_ready_i,
    output in_ready_o, out_data_o, out_valid_o
  );

endinterface

// File: rtl/scan_chain_ctrl_clk_gen.sv
// scan_clk_gen: divider for the scan clock phases.
// Ports: clk, rstn, run, hi in; phase_end strobe, scan_clk level out.
module scan_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic run,
  input  logic hi,
  output logic phase_end,
  output logic scan_clk
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] TOP = DW'(CLK_DIV - 1);

  logic [DW-1:0] cnt;

  assign phase_end = run && (cnt == TOP);
  assign scan_clk  = run && hi;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (!run || phase_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan-chain load/unload engine: shifts parser bytes into SI0, returns SO0.
// Ports: clk, rstn, start/busy/done, bus (in/out byte streams), scan pins;
// parity_o only when SCAN_PARITY_EN is defined.
module scan_chain_ctrl
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int CLK_DIV   = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic start_i,
  output logic busy_o,
  output logic done_o,
  scan_chain_ctrl_if.slave bus,
  output logic scan_clk_o,
  output logic scan_se_o,
  output logic scan_tm_o,
  output logic scan_in_o,
  input  logic scan_out_i
`ifdef SCAN_PARITY_EN
  ,
  output logic parity_o
`endif
);

  localparam int NBYTES    = (CHAIN_LEN + 7) / 8;
  localparam int LAST_BITS = CHAIN_LEN - 8 * (NBYTES - 1);
  localparam int BW        = $clog2(NBYTES + 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);
  localparam logic [3:0]    LAST_N    = 4'(LAST_BITS);

  state_t state, nxt;

  logic [7:0]    din;
  logic [7:0]    cap;
  logic [3:0]    bitcnt;
  logic [BW-1:0] bytecnt;

  logic shifting;
  logic phase_end;
  logic is_last;
  logic byte_done;

  assign shifting  = (state == SHIFT_LO) || (state == SHIFT_HI);
  assign is_last   = (bytecnt == LAST_BYTE);
  // Last byte stops after LAST_BITS so unused input bits never reach SI0.
  assign byte_done = (bitcnt + 4'd1) == (is_last ? LAST_N : 4'd8);

  scan_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk      (clk),
    .rstn     (rstn),
    .run      (shifting),
    .hi       (state == SHIFT_HI),
    .phase_end(phase_end),
    .scan_clk (scan_clk_o)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:     if (start_i) nxt = LOAD;
      LOAD:     if (bus.in_valid_i) nxt = SHIFT_LO;
      SHIFT_LO: if (phase_end) nxt = SHIFT_HI;
      SHIFT_HI: if (phase_end) nxt = byte_done ? EMIT : SHIFT_LO;
      EMIT:     if (bus.out_ready_i) nxt = is_last ? DONE : LOAD;
      DONE:     nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      din     <= '0;
      cap     <= '0;
      bitcnt  <= '0;
      bytecnt <= '0;
    end else begin
      if (state == IDLE && start_i) bytecnt <= '0;
      if (state == LOAD && bus.in_valid_i) begin
        din    <= bus.in_data_i;
        cap    <= '0;
        bitcnt <= '0;
      end
      // Sample SO0 just before the rising scan edge.
      if (state == SHIFT_LO && phase_end)
        cap[bitcnt[2:0]] <= scan_out_i;
      if (state == SHIFT_HI && phase_end)
        bitcnt <= bitcnt + 4'd1;
      if (state == EMIT && bus.out_ready_i && !is_last)
        bytecnt <= bytecnt + 1'b1;
    end
  end

`ifdef SCAN_PARITY_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      parity_o <= 1'b0;
    else if (state == IDLE && start_i)
      parity_o <= 1'b0;
    else if (state == SHIFT_LO && phase_end)
      parity_o <= parity_o ^ scan_out_i;
  end
`endif

  assign busy_o          = (state != IDLE);
  assign done_o          = (state == DONE);
  assign scan_se_o       = busy_o;
  assign scan_tm_o       = busy_o;
  assign scan_in_o       = shifting && din[bitcnt[2:0]];
  assign bus.in_ready_o  = (state == LOAD);
  assign bus.out_valid_o = (state == EMIT);
  assign bus.out_data_o  = cap;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl with a 12-flop chain model and CLK_DIV=1.
// Directed passes: plain, back-pressure, starvation, start-while-busy, reset.
module tb_scan_chain_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic busy, done;
  logic scan_clk, scan_se, scan_tm, scan_in, scan_out;
`ifdef SCAN_PARITY_EN
  logic parity;
`endif

  logic [11:0] model;
  logic [11:0] preload = 12'hA5C;
  int rises = 0;
  int dones = 0;
  int checks = 0;
  int failures = 0;

  scan_chain_ctrl_if bus ();

  scan_chain_ctrl #(
    .CHAIN_LEN(12),
    .CLK_DIV  (1)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start_i   (start),
    .busy_o    (busy),
    .done_o    (done),
    .bus       (bus.slave),
    .scan_clk_o(scan_clk),
    .scan_se_o (scan_se),
    .scan_tm_o (scan_tm),
    .scan_in_o (scan_in),
    .scan_out_i(scan_out)
`ifdef SCAN_PARITY_EN
    ,
    .parity_o  (parity)
`endif
  );

  always #5 clk = ~clk;

  assign scan_out = model[0];

  always @(posedge scan_clk) begin
    model <= {scan_in, model[11:1]};
    rises++;
  end

  always @(negedge clk) if (done) dones++;

  task automatic expect_eq(input string tag,
                           input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] outs();
    return {busy, done, bus.in_ready_o, bus.out_valid_o,
            scan_clk, scan_se, scan_tm, scan_in, 3'b000}
           | {3'b000, bus.out_data_o};
  endfunction

  task automatic wait_in_ready(input string tag);
    for (int i = 0; i < 200 && !bus.in_ready_o; i++) @(negedge clk);
    expect_eq(tag, bus.in_ready_o, 1);
  endtask

  task automatic wait_out_valid(input string tag);
    for (int i = 0; i < 200 && !bus.out_valid_o; i++) @(negedge clk);
    expect_eq(tag, bus.out_valid_o, 1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.in_data_i = b;
    bus.in_valid_i = 1'b1;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
  endtask

  task automatic begin_pass();
    model = preload;
    rises = 0;
    dones = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    expect_eq("busy_se_tm", {busy, scan_se, scan_tm}, 3'b111);
  endtask

  task automatic run_pass(input int in_gap,
                          input int out_hold,
                          input bit poke);
    logic [7:0] ins [2];
    logic [7:0] exp [2];
    int r0;
    int hi;
    logic [7:0] d0;
    ins[0] = 8'h3C; ins[1] = 8'h0F;
    exp[0] = 8'h5C; exp[1] = 8'h0A;
    begin_pass();
    for (int b = 0; b < 2; b++) begin
      wait_in_ready("in_ready");
      if (b == 1 && in_gap > 0) begin
        r0 = rises;
        hi = 0;
        repeat (in_gap) begin
          @(negedge clk);
          if (scan_clk || !bus.in_ready_o) hi++;
        end
        expect_eq("starve_idle", (rises - r0) + hi, 0);
      end
      send_byte(ins[b]);
      if (poke && b == 0) begin
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      wait_out_valid("out_valid");
      if (b == 0 && out_hold > 0) begin
        r0 = rises;
        hi = 0;
        d0 = bus.out_data_o;
        repeat (out_hold) begin
          @(negedge clk);
          if (scan_clk || !bus.out_valid_o || bus.in_ready_o ||
              bus.out_data_o != d0) hi++;
        end
        expect_eq("hold_stable", (rises - r0) + hi, 0);
      end
      expect_eq("out_byte", bus.out_data_o, exp[b]);
      bus.out_ready_i = 1'b1;
      @(negedge clk);
      bus.out_ready_i = 1'b0;
    end
    expect_eq("done_pulse", {done, busy}, 2'b11);
`ifdef SCAN_PARITY_EN
    expect_eq("parity", parity, ^preload);
`endif
    @(negedge clk);
    expect_eq("idle_after", {done, busy, scan_se, scan_tm}, 4'b0000);
    repeat (5) @(negedge clk);
    expect_eq("still_idle", busy, 0);
    expect_eq("rises", rises, 12);
    expect_eq("dones", dones, 1);
    expect_eq("model", model, 12'hF3C);
  endtask

  initial begin
    bus.in_data_i = '0;
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b0;
    model = preload;
    repeat (3) @(negedge clk);
    expect_eq("reset_outs", outs(), 0);
    rstn = 1'b1;
    @(negedge clk);
    expect_eq("idle_outs", outs(), 0);

    run_pass(0, 0, 1'b0);
    run_pass(0, 20, 1'b0);
    run_pass(15, 0, 1'b0);
    run_pass(0, 0, 1'b1);

    begin_pass();
    wait_in_ready("in_ready_rst");
    send_byte(8'h3C);
    for (int i = 0; i < 50 && !scan_clk; i++) @(negedge clk);
    expect_eq("reached_hi", scan_clk, 1);
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    #1;
    expect_eq("abort_outs", outs(), 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    expect_eq("post_rst_outs", outs(), 0);
    run_pass(0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
